// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding, the
// default EXT burst limit, and the base priority rule used by the FSM.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CPU  = 2'b01,
        EXT  = 2'b10
    } owner_e;

    localparam int MAX_EXT_BURST_DEF = 4;
    localparam int WAIT_CNT_W        = 16;

    // Strict priority: the external loader always wins over the CPU.
    function automatic owner_e base_next_owner(input logic ext_want, input logic cpu_want);
        if (ext_want)
            return EXT;
        else if (cpu_want)
            return CPU;
        return IDLE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on
// asynchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, never wrapping past the maximum value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port data memory (CPU vs. external loader).
// Ownership is registered, so a new request is served one cycle after it is
// first seen; the memory mux itself is combinational from the owner.
// Optional feature: define DMEM_ARB_STARVE_EN to let the CPU steal one cycle
// after MAX_EXT_BURST consecutive EXT cycles in which it was waiting.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_EXT_BURST = MAX_EXT_BURST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    // CPU side
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    // External loader side
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_adr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    // Shared memory port
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // Statistics
    output logic [15:0]       cpu_wait_cnt
);

    if (MAX_EXT_BURST < 1) begin : g_cfg_check
        $error("MAX_EXT_BURST must be at least 1");
    end

    owner_e owner;
    owner_e owner_next;

`ifdef DMEM_ARB_STARVE_EN
    // Wide enough to hold MAX_EXT_BURST with headroom, never zero width.
    localparam int SC_W = $clog2(MAX_EXT_BURST + 2);

    logic [SC_W-1:0] starve_cnt;
    logic [SC_W-1:0] starve_next;
    logic            starve_hit;

    // Count EXT cycles the CPU sat through; the cycle that reaches the limit
    // hands the next cycle to the CPU. Any other cycle restarts the count.
    always_comb begin
        starve_next = '0;
        starve_hit  = 1'b0;
        if ((owner == EXT) && cpu_req) begin
            if ((int'(starve_cnt) + 1) >= MAX_EXT_BURST)
                starve_hit = 1'b1;
            else
                starve_next = starve_cnt + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else
            starve_cnt <= starve_next;
    end
`endif

    // Next-owner selection: EXT first, then CPU, optionally overridden when
    // the CPU has waited out a full EXT burst.
    always_comb begin
        owner_next = base_next_owner(ext_req, cpu_req);
`ifdef DMEM_ARB_STARVE_EN
        if (starve_hit)
            owner_next = CPU;
`endif
    end

    // Owner state register; reset parks the port so nothing is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            owner <= IDLE;
        else
            owner <= owner_next;
    end

    // Memory port mux driven straight from the current owner. A requester
    // that drops its request stops writing in that same cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        case (owner)
            EXT: begin
                mem_we    = ext_we & ext_req;
                mem_adr   = ext_adr;
                mem_wdata = ext_wdata;
            end
            CPU: begin
                mem_we    = cpu_we & cpu_req;
                mem_adr   = cpu_adr;
                mem_wdata = cpu_wdata;
            end
            default: ;
        endcase
    end

    assign ext_gnt   = (owner == EXT) & ext_req;
    assign cpu_stall = cpu_req & ~((owner == CPU) & ~ext_gnt);
    assign cpu_rdata = mem_rdata;
    assign ext_rdata = mem_rdata;

    sat_counter #(
        .W (WAIT_CNT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cpu_stall),
        .count (cpu_wait_cnt)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the stimulus process pushes each
// expected memory beat, a negedge monitor pops and compares whenever the
// DUT actually serves a master.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_adr, cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        ext_req, ext_we;
    logic [31:0] ext_adr, ext_wdata;
    logic        ext_gnt;
    logic [31:0] ext_rdata;
    logic        mem_we;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic [15:0] cpu_wait_cnt;

    typedef struct packed {
        logic        is_ext;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
    } beat_t;

    beat_t exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    dmem_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .MAX_EXT_BURST (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_adr      (cpu_adr),
        .cpu_wdata    (cpu_wdata),
        .cpu_stall    (cpu_stall),
        .cpu_rdata    (cpu_rdata),
        .ext_req      (ext_req),
        .ext_we       (ext_we),
        .ext_adr      (ext_adr),
        .ext_wdata    (ext_wdata),
        .ext_gnt      (ext_gnt),
        .ext_rdata    (ext_rdata),
        .mem_we       (mem_we),
        .mem_adr      (mem_adr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .cpu_wait_cnt (cpu_wait_cnt)
    );

    // Memory model: read data is the inverted address.
    assign mem_rdata = ~mem_adr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every served beat must match the head of the queue.
    always @(negedge clk) begin
        beat_t e;
        if (ext_gnt || (cpu_req && !cpu_stall)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got gnt=%b adr=%h want none (t=%0t)", ext_gnt, mem_adr, $time);
            end else begin
                e = exp_q.pop_front();
                check("beat_owner", {31'd0, ext_gnt}, {31'd0, e.is_ext});
                check("beat_we",    {31'd0, mem_we},  {31'd0, e.we});
                check("beat_adr",   mem_adr, e.adr);
                if (e.we)
                    check("beat_wdata", mem_wdata, e.wdata);
                else if (e.is_ext)
                    check("ext_rdata", ext_rdata, ~e.adr);
                else
                    check("cpu_rdata", cpu_rdata, ~e.adr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_adr = '0; ext_wdata = '0;
    endtask

    task automatic push(input logic is_ext, input logic we, input logic [31:0] adr, input logic [31:0] wdata);
        beat_t b;
        b.is_ext = is_ext; b.we = we; b.adr = adr; b.wdata = wdata;
        exp_q.push_back(b);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset   = 1'b1;
        cpu_req = 1'b1;

        // Reset with a pending CPU request.
        step();
        check("rst_mem_we",   {31'd0, mem_we},    32'd0);
        check("rst_ext_gnt",  {31'd0, ext_gnt},   32'd0);
        check("rst_stall",    {31'd0, cpu_stall}, 32'd1);
        check("rst_wait_cnt", {16'd0, cpu_wait_cnt}, 32'd0);
        step();
        check("rst_wait_hold", {16'd0, cpu_wait_cnt}, 32'd0);
        idle_inputs();
        reset = 1'b0;

        // CPU write: stalled on the first cycle, served on the next.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h10; cpu_wdata = 32'hCAFE;
        #1;
        check("w_first_stall", {31'd0, cpu_stall}, 32'd1);
        check("w_first_we",    {31'd0, mem_we},    32'd0);
        step();
        push(1'b0, 1'b1, 32'h10, 32'hCAFE);
        check("w_we",    {31'd0, mem_we},    32'd1);
        check("w_adr",   mem_adr,            32'h10);
        check("w_stall", {31'd0, cpu_stall}, 32'd0);
        step();
        idle_inputs();
        check("w_wait_cnt", {16'd0, cpu_wait_cnt}, 32'd1);

        // Both request for 3 cycles: EXT wins from cycle 2, CPU stalled.
        do_reset();
        ext_req = 1'b1; ext_adr = 32'h20; cpu_req = 1'b1; cpu_adr = 32'h30;
        #1;
        check("both_c1_gnt",   {31'd0, ext_gnt},   32'd0);
        check("both_c1_stall", {31'd0, cpu_stall}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            step();
            ext_adr = 32'h21 + k;
            push(1'b1, 1'b0, 32'h21 + k, 32'h0);
            #1;
            check("both_gnt",   {31'd0, ext_gnt},   32'd1);
            check("both_stall", {31'd0, cpu_stall}, 32'd1);
        end
        step();
        check("both_wait_cnt", {16'd0, cpu_wait_cnt}, 32'd3);
        idle_inputs();
        #1;
        check("both_after_gnt", {31'd0, ext_gnt}, 32'd0);

        // EXT arrives while the CPU owns the port, then the CPU gets it back.
        do_reset();
        cpu_req = 1'b1; cpu_adr = 32'h60;
        #1;
        check("pre_c1_stall", {31'd0, cpu_stall}, 32'd1);
        step();
        push(1'b0, 1'b0, 32'h60, 32'h0);
        ext_req = 1'b1; ext_we = 1'b1; ext_adr = 32'h70; ext_wdata = 32'hBEEF;
        #1;
        check("pre_c2_gnt",   {31'd0, ext_gnt},   32'd0);
        check("pre_c2_stall", {31'd0, cpu_stall}, 32'd0);
        step();
        push(1'b1, 1'b1, 32'h70, 32'hBEEF);
        #1;
        check("pre_c3_gnt",   {31'd0, ext_gnt},   32'd1);
        check("pre_c3_stall", {31'd0, cpu_stall}, 32'd1);
        step();
        ext_req = 1'b0; ext_we = 1'b0;
        #1;
        check("pre_c4_gnt",   {31'd0, ext_gnt},   32'd0);
        check("pre_c4_we",    {31'd0, mem_we},    32'd0);
        check("pre_c4_stall", {31'd0, cpu_stall}, 32'd1);
        step();
        cpu_adr = 32'h61;
        push(1'b0, 1'b0, 32'h61, 32'h0);
        #1;
        check("pre_c5_stall", {31'd0, cpu_stall}, 32'd0);
        step();
        idle_inputs();
        check("pre_wait_cnt", {16'd0, cpu_wait_cnt}, 32'd3);

        // Reset lands in the middle of an EXT write burst.
        do_reset();
        ext_req = 1'b1; ext_we = 1'b1; ext_adr = 32'h50; ext_wdata = 32'h1234;
        #1;
        check("rw_c1_gnt", {31'd0, ext_gnt}, 32'd0);
        step();
        push(1'b1, 1'b1, 32'h50, 32'h1234);
        #1;
        check("rw_c2_we", {31'd0, mem_we}, 32'd1);
        step();
        ext_adr = 32'h51; ext_wdata = 32'h5678;
        #1;
        check("rw_c3_we",  {31'd0, mem_we}, 32'd1);
        check("rw_c3_adr", mem_adr,         32'h51);
        reset = 1'b1;
        #1;
        check("rw_rst_we",    {31'd0, mem_we},  32'd0);
        check("rw_rst_gnt",   {31'd0, ext_gnt}, 32'd0);
        check("rw_rst_adr",   mem_adr,          32'h0);
        check("rw_rst_wdata", mem_wdata,        32'h0);
        idle_inputs();
        step();
        reset = 1'b0;

        // Both held for a long run: starvation relief only with the macro.
        do_reset();
        ext_req = 1'b1; ext_adr = 32'h80; cpu_req = 1'b1; cpu_adr = 32'h90;
        #1;
        check("st_c1_stall", {31'd0, cpu_stall}, 32'd1);
        for (int c = 2; c <= 8; c++) begin
            logic cpu_turn;
            step();
`ifdef DMEM_ARB_STARVE_EN
            cpu_turn = (c == 6);
`else
            cpu_turn = 1'b0;
`endif
            if (cpu_turn)
                push(1'b0, 1'b0, 32'h90, 32'h0);
            else
                push(1'b1, 1'b0, 32'h80, 32'h0);
            #1;
            check("st_gnt",   {31'd0, ext_gnt},   {31'd0, ~cpu_turn});
            check("st_stall", {31'd0, cpu_stall}, {31'd0, ~cpu_turn});
        end
        step();
        idle_inputs();

`ifndef DMEM_ARB_STARVE_EN
        // Wait counter saturation under a permanently stalled CPU.
        do_reset();
        ext_req = 1'b1; ext_adr = 32'h40; cpu_req = 1'b1; cpu_adr = 32'h44;
        for (int n = 1; n <= 65534; n++) begin
            step();
            push(1'b1, 1'b0, 32'h40, 32'h0);
        end
        check("sat_fffe", {16'd0, cpu_wait_cnt}, 32'hFFFE);
        for (int n = 0; n < 3; n++) begin
            step();
            push(1'b1, 1'b0, 32'h40, 32'h0);
            check("sat_ffff", {16'd0, cpu_wait_cnt}, 32'hFFFF);
        end
        step();
        idle_inputs();
`endif

        step();
        step();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL beats_left: got %0d want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, data-memory address width.
REQ-002 Parameter DATA_W, 32, data-memory word width.
REQ-003 Parameter MAX_EXT_BURST, 4, number of consecutive EXT grants allowed while the CPU waits; only used under REQ-025.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Ports cpu_req / cpu_we, input, 1 each: CPU access request and write enable.
REQ-007 Ports cpu_adr, input, ADDR_W, and cpu_wdata, input, DATA_W: CPU address and store data.
REQ-008 Port cpu_stall, output, 1: CPU must hold PC and request this cycle.
REQ-009 Port cpu_rdata, output, DATA_W: load data returned to the CPU.
REQ-010 Ports ext_req / ext_we, input, 1 each: external loader request and write enable.
REQ-011 Ports ext_adr, input, ADDR_W, and ext_wdata, input, DATA_W: external address and data.
REQ-012 Port ext_gnt, output, 1: external beat is performed this cycle.
REQ-013 Port ext_rdata, output, DATA_W: external read data, valid when ext_gnt=1 and ext_we=0.
REQ-014 Ports mem_we, output, 1; mem_adr, output, ADDR_W; mem_wdata, output, DATA_W: the shared memory port.
REQ-015 Port mem_rdata, input, DATA_W: combinational read data from memory.
REQ-016 Port cpu_wait_cnt, output, 16: saturating count of stalled CPU cycles.

Function
REQ-017 Registered owner state SHALL take one of three values: IDLE, CPU or EXT.
REQ-018 Owner transitions: next=EXT if ext_req=1; else CPU if cpu_req=1; else IDLE (EXT has strict priority unless REQ-025 overrides).
REQ-019 Arbitration latency SHALL be one cycle: a request first seen in cycle N is served in cycle N+1 at the earliest.
REQ-020 Memory mux SHALL select from owner combinationally. EXT drives ext_adr/ext_wdata and mem_we=ext_we&ext_req; CPU drives cpu_adr/cpu_wdata and mem_we=cpu_we&cpu_req; IDLE drives mem_we=0 and adr/wdata=0.
REQ-021 ext_gnt SHALL equal (owner==EXT)&ext_req; each granted cycle is one beat. A requester holding ext_req gets back-to-back beats, and dropping ext_req ends the burst.
REQ-022 cpu_stall SHALL equal cpu_req & ~((owner==CPU)&~ext_gnt); a CPU request with owner≠CPU stalls.
REQ-023 cpu_rdata and ext_rdata SHALL both equal mem_rdata.
REQ-024 cpu_wait_cnt SHALL increment by 1 on each clock edge with cpu_stall=1, hold otherwise, and saturate at 0xFFFF without wrapping.

Configuration
REQ-025 With macro DMEM_ARB_STARVE_EN defined, a counter SHALL track consecutive EXT-owned cycles with cpu_req=1. When the counter reaches MAX_EXT_BURST and cpu_req=1, next owner is CPU for exactly one cycle and the counter clears. The counter also clears on any non-EXT cycle.
REQ-026 Without DMEM_ARB_STARVE_EN, the counter SHALL be absent, EXT priority SHALL be absolute, and MAX_EXT_BURST SHALL be ignored.

Reset
REQ-027 reset=1 SHALL immediately force owner=IDLE, starvation counter=0 and cpu_wait_cnt=0, independent of clk.
REQ-028 During and right after reset: mem_we=0, ext_gnt=0, cpu_stall=cpu_req. A write in progress when reset asserts SHALL be dropped in the same cycle.

Structure
REQ-029 Shared package dmem_arb_pkg SHALL hold the owner encoding (IDLE=2'b00, CPU=2'b01, EXT=2'b10) and the MAX_EXT_BURST default.
REQ-030 The 16-bit saturating counter SHALL be a sub-module named sat_counter. The rest stays flat.

Verification
REQ-031 Reset pulse with cpu_req=1 -> mem_we=0, ext_gnt=0, cpu_stall=1, cpu_wait_cnt=0.
REQ-032 cpu_req=1, cpu_we=1, cpu_adr=0x10, cpu_wdata=0xCAFE, ext idle -> cycle after request, mem_we=1, mem_adr=0x10, cpu_stall=0.
REQ-033 ext_req and cpu_req both high for 3 cycles (macro off) -> ext_gnt=1 from cycle 2, CPU stalled throughout, cpu_wait_cnt=3.
REQ-034 Macro on, MAX_EXT_BURST=4, ext_req and cpu_req held high -> EXT beats 4 cycles, CPU 1 cycle, then EXT resumes.
REQ-035 Force cpu_wait_cnt to 0xFFFE with stall held 3 cycles -> reads 0xFFFF and holds.
REQ-036 Assert reset mid-EXT write (ext_we=1) -> mem_we falls in the same cycle, owner=IDLE.
